// File: rtl/lcd_pattern_gen_if.sv
// LCD pin bundle driven by lcd_pattern_gen: sync, data enable, pixel colour,
// active-area coordinates and the frame-start strobe.
interface lcd_pattern_gen_if #(parameter int COLOR_W = 8);
  logic                   lcd_hs;
  logic                   lcd_vs;
  logic                   lcd_de;
  logic [3*COLOR_W-1:0]   lcd_rgb;
  logic [10:0]            pixel_xpos;
  logic [10:0]            pixel_ypos;
  logic                   frame_start;

  modport master (output lcd_hs, lcd_vs, lcd_de, lcd_rgb, pixel_xpos, pixel_ypos, frame_start);
  modport slave  (input  lcd_hs, lcd_vs, lcd_de, lcd_rgb, pixel_xpos, pixel_ypos, frame_start);
endinterface

// File: rtl/lcd_pattern_gen.sv
// LCD test-pattern source: H/V timing plus bars/gradient/checker/solid engine.
// Define LCD_PAT_SCROLL_EN to make the colour bars scroll left by SCROLL_STEP px per frame.
module lcd_pattern_gen #(
  parameter int H_SYNC      = 1,
  parameter int H_BACK      = 46,
  parameter int H_DISP      = 800,
  parameter int H_FRONT     = 210,
  parameter int V_SYNC      = 1,
  parameter int V_BACK      = 23,
  parameter int V_DISP      = 480,
  parameter int V_FRONT     = 22,
  parameter int NUM_BARS    = 8,
  parameter int COLOR_W     = 8,
  parameter int CHK_LOG2    = 5,
  parameter int SCROLL_STEP = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [1:0]           mode_i,
  input  logic [3*COLOR_W-1:0] solid_rgb_i,
  lcd_pattern_gen_if.master    lcd
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int BAR_W   = H_DISP / NUM_BARS;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] V_ACT    = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] H_ACT_E  = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] V_ACT_E  = 11'(V_SYNC + V_BACK + V_DISP);
  localparam logic [11:0] BAR_W_C  = 12'(BAR_W);
  localparam logic [11:0] BAR_MAX  = 12'(NUM_BARS - 1);

  localparam logic [COLOR_W-1:0] C1 = '1;
  localparam logic [COLOR_W-1:0] C0 = '0;

  if (NUM_BARS < 1 || NUM_BARS > H_DISP || SCROLL_STEP < 0 ||
      H_TOTAL > 2047 || V_TOTAL > 2047 || CHK_LOG2 > 10) begin : g_bad_cfg
    $error("lcd_pattern_gen: unsupported parameter set");
  end

  typedef enum logic [1:0] {MODE_BARS, MODE_GRAD, MODE_CHK, MODE_SOLID} mode_e;

  logic [10:0]          h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  mode_e                mode_q, mode_d, mode_cur;
  logic [3*COLOR_W-1:0] solid_q, solid_d, solid_cur;
  logic                 hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d, pat;
  logic [10:0]          xpos_q, xpos_d, ypos_q, ypos_d;
  logic [10:0]          x_cur, y_cur;
  logic [11:0]          sx, bar_idx;
  logic                 frame_top;

  always_comb begin
    frame_top = (h_cnt_q == '0) && (v_cnt_q == '0);
    h_cnt_d   = h_cnt_q + 11'd1;
    v_cnt_d   = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
    end
    // The frame's first cycle already uses the freshly sampled mode/colour.
    mode_cur  = frame_top ? mode_e'(mode_i) : mode_q;
    solid_cur = frame_top ? solid_rgb_i : solid_q;
    mode_d    = mode_cur;
    solid_d   = solid_cur;
  end

`ifdef LCD_PAT_SCROLL_EN
  localparam logic [11:0] STEP_C = 12'(SCROLL_STEP % H_DISP);
  localparam logic [11:0] H_DISP_C = 12'(H_DISP);
  logic [11:0] offset_q, offset_d;

  always_comb begin
    offset_d = offset_q;
    if (frame_top) begin
      offset_d = offset_q + STEP_C;
      if (offset_d >= H_DISP_C) offset_d = offset_d - H_DISP_C;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) offset_q <= '0;
    else         offset_q <= offset_d;
  end
`endif

  always_comb begin
    x_cur = h_cnt_q - H_ACT;
    y_cur = v_cnt_q - V_ACT;
    de_d  = (h_cnt_q >= H_ACT) && (h_cnt_q < H_ACT_E) &&
            (v_cnt_q >= V_ACT) && (v_cnt_q < V_ACT_E);
`ifdef LCD_PAT_SCROLL_EN
    sx = {1'b0, x_cur} + offset_q;
    if (sx >= H_DISP_C) sx = sx - H_DISP_C;
`else
    sx = {1'b0, x_cur};
`endif
    // Leftover pixels from an uneven split fold into the last bar.
    bar_idx = sx / BAR_W_C;
    if (bar_idx > BAR_MAX) bar_idx = BAR_MAX;

    pat = '0;
    unique case (mode_cur)
      MODE_BARS: begin
        case (bar_idx & 12'd7)
          12'd0:   pat = {C1, C1, C1};
          12'd1:   pat = {C1, C1, C0};
          12'd2:   pat = {C0, C1, C1};
          12'd3:   pat = {C0, C1, C0};
          12'd4:   pat = {C1, C0, C1};
          12'd5:   pat = {C1, C0, C0};
          12'd6:   pat = {C0, C0, C1};
          default: pat = {C0, C0, C0};
        endcase
      end
      MODE_GRAD:  pat = {3{COLOR_W'(x_cur)}};
      MODE_CHK:   pat = (x_cur[CHK_LOG2] ^ y_cur[CHK_LOG2]) ? {C1, C1, C1} : {C0, C0, C0};
      MODE_SOLID: pat = solid_cur;
      default:    pat = '0;
    endcase

    hs_d   = !(h_cnt_q < 11'(H_SYNC));
    vs_d   = !(v_cnt_q < 11'(V_SYNC));
    rgb_d  = de_d ? pat   : '0;
    xpos_d = de_d ? x_cur : '0;
    ypos_d = de_d ? y_cur : '0;
    fs_d   = frame_top;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      mode_q  <= MODE_BARS;
      solid_q <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      fs_q    <= fs_d;
    end
  end

  assign lcd.lcd_hs      = hs_q;
  assign lcd.lcd_vs      = vs_q;
  assign lcd.lcd_de      = de_q;
  assign lcd.lcd_rgb     = rgb_q;
  assign lcd.pixel_xpos  = xpos_q;
  assign lcd.pixel_ypos  = ypos_q;
  assign lcd.frame_start = fs_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen on a tiny 22x7 raster (16x4 active, 4 bars of 4 px).
module tb_lcd_pattern_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [23:0] solid = 24'h0;
  int checks = 0;
  int errors = 0;

  logic [23:0] fb [4][16];
  int hs_lo, vs_lo, de_n, fs_n, bad_idle, first_de;
  logic [23:0] bar_exp [4] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00};

  lcd_pattern_gen_if #(.COLOR_W(8)) lcd();

  lcd_pattern_gen #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(16), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .NUM_BARS(4), .COLOR_W(8), .CHK_LOG2(1), .SCROLL_STEP(1)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .mode_i(mode), .solid_rgb_i(solid), .lcd(lcd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  // Captures one frame starting at the next frame_start; optionally changes mode mid-frame.
  task automatic capture(input int chg_at, input logic [1:0] chg_mode, input logic [23:0] chg_rgb);
    int waited = 0;
    while (!lcd.frame_start && waited < 400) begin @(negedge clk); waited++; end
    checks++;
    if (!lcd.frame_start) begin
      errors++;
      $display("FAIL frame_start_wait: got no pulse in %0d cycles, required one", waited);
    end
    hs_lo = 0; vs_lo = 0; de_n = 0; fs_n = 0; bad_idle = 0; first_de = -1;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 16; c++) fb[r][c] = 24'hDEAD00;
    for (int i = 0; i < 154; i++) begin
      if (i == chg_at) begin mode = chg_mode; solid = chg_rgb; end
      if (!lcd.lcd_hs) hs_lo++;
      if (!lcd.lcd_vs) vs_lo++;
      if (lcd.frame_start) fs_n++;
      if (lcd.lcd_de) begin
        de_n++;
        if (first_de < 0) first_de = i;
        if (lcd.pixel_xpos < 16 && lcd.pixel_ypos < 4) fb[lcd.pixel_ypos][lcd.pixel_xpos] = lcd.lcd_rgb;
        else bad_idle++;
      end else if (lcd.lcd_rgb != 0 || lcd.pixel_xpos != 0 || lcd.pixel_ypos != 0) begin
        bad_idle++;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_timing(input string tag);
    checks++; if (hs_lo !== 14) begin errors++; $display("FAIL %s hs_low: got %0d, required 14", tag, hs_lo); end
    checks++; if (vs_lo !== 22) begin errors++; $display("FAIL %s vs_low: got %0d, required 22", tag, vs_lo); end
    checks++; if (de_n !== 64) begin errors++; $display("FAIL %s de_count: got %0d, required 64", tag, de_n); end
    checks++; if (fs_n !== 1) begin errors++; $display("FAIL %s fs_count: got %0d, required 1", tag, fs_n); end
    checks++; if (first_de !== 48) begin errors++; $display("FAIL %s first_de: got %0d, required 48", tag, first_de); end
    checks++; if (bad_idle !== 0) begin errors++; $display("FAIL %s idle_zero: got %0d bad, required 0", tag, bad_idle); end
    checks++; if (lcd.frame_start !== 1'b1) begin errors++; $display("FAIL %s fs_period: got %b at +154, required 1", tag, lcd.frame_start); end
  endtask

  task automatic test_reset;
    rst = 1'b1; mode = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({lcd.lcd_hs, lcd.lcd_vs, lcd.lcd_de, lcd.frame_start} !== 4'b1100 || lcd.lcd_rgb !== 24'h0 ||
        lcd.pixel_xpos !== 11'd0 || lcd.pixel_ypos !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: hs/vs/de/fs=%b%b%b%b rgb=%h, required 1100 rgb=000000",
               lcd.lcd_hs, lcd.lcd_vs, lcd.lcd_de, lcd.frame_start, lcd.lcd_rgb);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({lcd.frame_start, lcd.lcd_hs, lcd.lcd_vs, lcd.lcd_de} !== 4'b1000) begin
      errors++;
      $display("FAIL first_cycle: fs/hs/vs/de=%b%b%b%b, required 1000",
               lcd.frame_start, lcd.lcd_hs, lcd.lcd_vs, lcd.lcd_de);
    end
  endtask

  task automatic test_bars;
    capture(-1, 2'd0, 24'h0);
    check_timing("bars");
    for (int y = 0; y < 4; y += 3)
      for (int x = 0; x < 16; x++) begin
        checks++;
        if (fb[y][x] !== bar_exp[x/4]) begin
          errors++; $display("FAIL bars y%0d x%0d: got %h, required %h", y, x, fb[y][x], bar_exp[x/4]);
        end
      end
  endtask

  task automatic test_gradient;
    mode = 2'd1;
    @(negedge clk);
    capture(-1, 2'd0, 24'h0);
    check_timing("grad");
    checks++;
    if (fb[1][5] !== 24'h050505) begin errors++; $display("FAIL grad x5: got %h, required 050505", fb[1][5]); end
    for (int x = 0; x < 16; x++) begin
      logic [7:0] b;
      b = 8'(x);
      checks++;
      if (fb[2][x] !== {b, b, b}) begin errors++; $display("FAIL grad x%0d: got %h, required %h", x, fb[2][x], {b, b, b}); end
    end
  endtask

  task automatic test_checker;
    mode = 2'd2;
    @(negedge clk);
    capture(-1, 2'd0, 24'h0);
    checks++; if (fb[0][2] !== 24'hFFFFFF) begin errors++; $display("FAIL chk y0x2: got %h, required FFFFFF", fb[0][2]); end
    checks++; if (fb[0][0] !== 24'h000000) begin errors++; $display("FAIL chk y0x0: got %h, required 000000", fb[0][0]); end
    checks++; if (fb[2][0] !== 24'hFFFFFF) begin errors++; $display("FAIL chk y2x0: got %h, required FFFFFF", fb[2][0]); end
    checks++; if (fb[3][3] !== 24'h000000) begin errors++; $display("FAIL chk y3x3: got %h, required 000000", fb[3][3]); end
    checks++; if (fb[1][13] !== 24'h000000) begin errors++; $display("FAIL chk y1x13: got %h, required 000000", fb[1][13]); end
    checks++; if (fb[3][5] !== 24'hFFFFFF) begin errors++; $display("FAIL chk y3x5: got %h, required FFFFFF", fb[3][5]); end
  endtask

  task automatic test_mode_switch;
    int bad;
    mode = 2'd0; solid = 24'h0;
    @(negedge clk);
    capture(70, 2'd3, 24'h123456);
    bad = 0;
    for (int y = 0; y < 4; y++) for (int x = 0; x < 16; x++) if (fb[y][x] !== bar_exp[x/4]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL switch_same_frame: %0d px not bars, required 0", bad); end
    capture(-1, 2'd0, 24'h0);
    check_timing("solid");
    bad = 0;
    for (int y = 0; y < 4; y++) for (int x = 0; x < 16; x++) if (fb[y][x] !== 24'h123456) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL switch_next_frame: %0d px not 123456, required 0", bad); end
  endtask

  task automatic test_reset_midline;
    while (!lcd.frame_start) @(negedge clk);
    repeat (52) @(negedge clk);
    checks++;
    if (lcd.lcd_de !== 1'b1 || lcd.lcd_rgb !== 24'h123456 || lcd.pixel_xpos !== 11'd4) begin
      errors++; $display("FAIL pre_reset: de=%b rgb=%h x=%0d, required 1 123456 4", lcd.lcd_de, lcd.lcd_rgb, lcd.pixel_xpos);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({lcd.lcd_hs, lcd.lcd_vs, lcd.lcd_de} !== 3'b110 || lcd.lcd_rgb !== 24'h0 || lcd.pixel_xpos !== 11'd0) begin
      errors++; $display("FAIL midline_reset: hs/vs/de=%b%b%b rgb=%h, required 110 000000",
                         lcd.lcd_hs, lcd.lcd_vs, lcd.lcd_de, lcd.lcd_rgb);
    end
    mode = 2'd2;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (lcd.frame_start !== 1'b1 || lcd.lcd_hs !== 1'b0) begin
      errors++; $display("FAIL restart: fs=%b hs=%b, required 1 0", lcd.frame_start, lcd.lcd_hs);
    end
    capture(-1, 2'd0, 24'h0);
    check_timing("restart");
    checks++; if (fb[0][2] !== 24'hFFFFFF) begin errors++; $display("FAIL restart_chk: got %h, required FFFFFF", fb[0][2]); end
  endtask

  initial begin
    test_reset;
    test_bars;
    test_gradient;
    test_checker;
    test_mode_switch;
    test_reset_midline;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
